// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and vote helper for the UART receiver
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchroniser, start-edge detector and mid-bit 2-of-3 vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          baud_tick,
    input  logic                          serial_in,
    input  logic [$clog2(OVERSAMPLE)-1:0] tick_cnt,
    output logic                          bit_val,
    output logic                          bit_strobe,
    output logic                          fall_edge
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_FIRST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE / 2 + 1);

    logic       sync_a;
    logic       sync_b;
    logic       edge_q;
    logic       armed;
    logic [1:0] settle;
    logic       samp_a;
    logic       samp_b;

    // The edge detector stays disarmed until the flushed synchroniser has seen the
    // line high, so a line held low across reset release cannot fake a start edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            edge_q <= 1'b1;
            settle <= 2'd0;
            armed  <= 1'b0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            sync_a <= serial_in;
            sync_b <= sync_a;
            edge_q <= sync_b;
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd3 && sync_b) begin
                armed <= 1'b1;
            end
            if (baud_tick && tick_cnt == T_FIRST) begin
                samp_a <= sync_b;
            end
            if (baud_tick && tick_cnt == T_MID) begin
                samp_b <= sync_b;
            end
        end
    end

    assign fall_edge  = armed & edge_q & ~sync_b;
    assign bit_strobe = baud_tick && (tick_cnt == T_LAST);
    assign bit_val    = majority3(samp_a, samp_b, sync_b);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with single-entry holding register
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PARITY_EVEN,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 BAUD_TICK,
    input  logic                 SERIAL_IN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_END   = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);
    localparam logic          HAS_PAR = (PARITY_MODE != PARITY_NONE);
    localparam logic          ODD_SEL = (PARITY_MODE == PARITY_ODD);

    rx_state_t              state;
    logic [TW-1:0]          tick_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_err_acc;
    logic                   frm_err_acc;
    logic                   bit_val;
    logic                   bit_strobe;
    logic                   fall_edge;
    logic                   bit_end;
    logic                   frame_done;
    logic                   frame_ferr;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk        (CLK),
        .clr        (CLR),
        .baud_tick  (BAUD_TICK),
        .serial_in  (SERIAL_IN),
        .tick_cnt   (tick_cnt),
        .bit_val    (bit_val),
        .bit_strobe (bit_strobe),
        .fall_edge  (fall_edge)
    );

    assign bit_end    = BAUD_TICK && (tick_cnt == T_END);
    assign frame_done = (state == RX_STOP) && bit_strobe && (bit_cnt == SB_LAST);
    assign frame_ferr = frm_err_acc | ~bit_val;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state       <= RX_IDLE;
            BUSY        <= 1'b0;
            tick_cnt    <= '0;
            bit_cnt     <= 4'd0;
            shreg       <= '0;
            par_err_acc <= 1'b0;
            frm_err_acc <= 1'b0;
        end else begin
            if (BAUD_TICK) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
            end
            case (state)
                RX_IDLE: begin
                    if (fall_edge) begin
                        tick_cnt    <= '0;
                        bit_cnt     <= 4'd0;
                        par_err_acc <= 1'b0;
                        frm_err_acc <= 1'b0;
                        state       <= RX_START;
                        BUSY        <= 1'b1;
                    end
                end
                RX_START: begin
                    if (bit_strobe && bit_val) begin
                        state <= RX_IDLE;
                        BUSY  <= 1'b0;
                    end else if (bit_end) begin
                        state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (bit_strobe) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_cnt == DB_LAST) begin
                            bit_cnt <= 4'd0;
                            state   <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (bit_strobe) begin
                        par_err_acc <= ((^shreg) ^ bit_val) != ODD_SEL;
                    end
                    if (bit_end) begin
                        state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leave at the last stop bit's decision tick so an early next start edge is seen.
                    if (bit_strobe) begin
                        frm_err_acc <= frame_ferr;
                        if (bit_cnt == SB_LAST) begin
                            state <= RX_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else if (bit_end) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (frame_done) begin
            if (!DATA_VALID || DATA_READY) begin
                DATA_OUT   <= shreg;
                PARITY_ERR <= HAS_PAR & par_err_acc;
                FRAME_ERR  <= frame_ferr;
                DATA_VALID <= 1'b1;
                OVERRUN    <= 1'b0;
            end else begin
                OVERRUN <= 1'b1;
            end
        end else if (DATA_VALID && DATA_READY) begin
            DATA_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for 8E1 and 7O2 receiver instances
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       tick = 1'b0;
    logic       line8 = 1'b1;
    logic       line7 = 1'b1;
    logic       rdy8 = 1'b1;
    logic       rdy7 = 1'b1;
    logic [7:0] dout8;
    logic [6:0] dout7;
    logic       dv8, pe8, fe8, ov8, busy8;
    logic       dv7, pe7, fe7, ov7, busy7;

    int checks = 0;
    int failures = 0;
    logic [10:0] exp8_q[$];
    logic [10:0] exp7_q[$];

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_rx8 (
        .CLK(clk), .CLR(clr), .BAUD_TICK(tick), .SERIAL_IN(line8),
        .DATA_OUT(dout8), .DATA_VALID(dv8), .DATA_READY(rdy8),
        .PARITY_ERR(pe8), .FRAME_ERR(fe8), .OVERRUN(ov8), .BUSY(busy8)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(16)) u_rx7 (
        .CLK(clk), .CLR(clr), .BAUD_TICK(tick), .SERIAL_IN(line7),
        .DATA_OUT(dout7), .DATA_VALID(dv7), .DATA_READY(rdy7),
        .PARITY_ERR(pe7), .FRAME_ERR(fe7), .OVERRUN(ov7), .BUSY(busy7)
    );

    initial forever #5 clk = ~clk;

    // One baud tick every 4 clocks, driven on the falling edge.
    initial begin : tick_gen
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tick = (tcnt == 0);
            tcnt = (tcnt + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        return {ov, fe, pe, d};
    endfunction

    function automatic logic [15:0] frame8(input logic [7:0] d, input logic p, input logic st);
        return {5'b11111, st, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame7(input logic [6:0] d, input logic p);
        return {5'b11111, 1'b1, 1'b1, p, d, 1'b0};
    endfunction

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line8 = v;
        else line7 = v;
    endtask

    // Each bit is 16 tick-long segments; segment 6/7/8 feeds the three mid-bit samples.
    task automatic send_bits(input int which, input logic [15:0] bits, input int nbits,
                             input int flip, input int last_segs);
        for (int b = 0; b < nbits; b++) begin
            int segs;
            segs = (b == nbits - 1) ? last_segs : 16;
            for (int s = 0; s < segs; s++) begin
                logic v;
                v = bits[b];
                if (flip != 0 && s == 6 + (b % 3)) v = ~v;
                set_line(which, v);
                wait_tick();
            end
        end
    endtask

    initial begin : mon8
        logic pv, pr;
        logic [10:0] e;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (dv8 && (!pv || pr)) begin
                if (exp8_q.size() == 0) begin
                    check("rx8_unexpected_word", pk(dout8, pe8, fe8, ov8), 32'hFFFF_FFFF);
                end else begin
                    e = exp8_q.pop_front();
                    check("rx8_word", pk(dout8, pe8, fe8, ov8), e);
                end
            end
            pv = dv8;
            pr = rdy8;
        end
    end

    initial begin : mon7
        logic pv, pr;
        logic [10:0] e;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (dv7 && (!pv || pr)) begin
                if (exp7_q.size() == 0) begin
                    check("rx7_unexpected_word", pk({1'b0, dout7}, pe7, fe7, ov7), 32'hFFFF_FFFF);
                end else begin
                    e = exp7_q.pop_front();
                    check("rx7_word", pk({1'b0, dout7}, pe7, fe7, ov7), e);
                end
            end
            pv = dv7;
            pr = rdy7;
        end
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check("reset8_during", {dout8, dv8, pe8, fe8, ov8, busy8}, 0);
        clr = 1'b1;
        repeat (10) @(negedge clk);
        check("reset8_after", {dout8, dv8, pe8, fe8, ov8, busy8}, 0);
        check("reset7_after", {dout7, dv7, pe7, fe7, ov7, busy7}, 0);
        idle_ticks(2);

        exp8_q.push_back(pk(8'hA5, 1'b0, 1'b0, 1'b0));
        send_bits(0, frame8(8'hA5, 1'b0, 1'b1), 11, 0, 16);
        idle_ticks(3);
        exp8_q.push_back(pk(8'hA5, 1'b1, 1'b0, 1'b0));
        send_bits(0, frame8(8'hA5, 1'b1, 1'b1), 11, 0, 16);
        idle_ticks(3);
        exp8_q.push_back(pk(8'h00, 1'b0, 1'b1, 1'b0));
        send_bits(0, frame8(8'h00, 1'b0, 1'b0), 11, 0, 16);
        line8 = 1'b1;
        idle_ticks(4);

        line8 = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("start_latency_2clk_busy", busy8, 1'b0);
        @(posedge clk); @(negedge clk);
        check("start_latency_3clk_busy", busy8, 1'b1);
        idle_ticks(4);
        line8 = 1'b1;
        n = 0;
        while (busy8 && n < 9) begin
            wait_tick();
            n++;
        end
        check("glitch_busy_clear", busy8, 1'b0);
        idle_ticks(8);

        exp8_q.push_back(pk(8'h5A, 1'b0, 1'b0, 1'b0));
        send_bits(0, frame8(8'h5A, 1'b0, 1'b1), 11, 1, 16);
        idle_ticks(3);

        rdy8 = 1'b0;
        exp8_q.push_back(pk(8'h3C, 1'b0, 1'b0, 1'b0));
        send_bits(0, frame8(8'h3C, 1'b0, 1'b1), 11, 0, 16);
        send_bits(0, frame8(8'hC3, 1'b0, 1'b1), 11, 0, 16);
        idle_ticks(2);
        check("overrun_data_held", dout8, 8'h3C);
        check("overrun_valid_held", dv8, 1'b1);
        check("overrun_flag", ov8, 1'b1);
        rdy8 = 1'b1;
        @(negedge clk);
        check("accept_valid_drop", dv8, 1'b0);
        check("accept_overrun_drop", ov8, 1'b0);
        idle_ticks(3);

        exp7_q.push_back(pk(8'h55, 1'b0, 1'b0, 1'b0));
        exp7_q.push_back(pk(8'h2A, 1'b0, 1'b0, 1'b0));
        send_bits(1, frame7(7'h55, 1'b1), 11, 0, 10);
        send_bits(1, frame7(7'h2A, 1'b0), 11, 0, 16);
        idle_ticks(4);

        send_bits(0, frame8(8'h00, 1'b0, 1'b1), 5, 0, 5);
        clr = 1'b0;
        @(negedge clk); @(negedge clk);
        check("clr_mid_frame", {dout8, dv8, pe8, fe8, ov8, busy8}, 0);
        clr = 1'b1;
        idle_ticks(30);
        check("clr_release_line_low", {dout8, dv8, pe8, fe8, ov8, busy8}, 0);
        line8 = 1'b1;
        idle_ticks(4);
        exp8_q.push_back(pk(8'h81, 1'b0, 1'b0, 1'b0));
        send_bits(0, frame8(8'h81, 1'b0, 1'b1), 11, 0, 16);
        idle_ticks(4);

        check("rx8_queue_drained", exp8_q.size(), 0);
        check("rx7_queue_drained", exp7_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
